song_select_ctrl: RTL

- Controller that sequences the song-choose panel renderer.
- Tracks the selection cursor from button pulses and drives `repertoire_page` and `page_song_id`.
- On every page change, fetches the four song names for the new page from the song-name ROM over a req/ack handshake.
- Stages the fetched names and commits them to `songname_1..4` in one cycle, so the panel never shows a half-updated page.
- Sits between the debounced key logic, the song-name ROM and the panel renderer; all in the `vga_clk` domain.

---
 rtl/song_select_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/song_select_ctrl.sv
// Song-choose panel sequencer: cursor tracking, page fetch from the song-name ROM, atomic name commit.
// Build option: define SONG_WRAP_EN to make the cursor wrap at both ends instead of saturating.
module song_select_ctrl #(
   parameter int                SONG_COUNT = 8,
   parameter int                NAME_W     = 160,
   parameter logic [NAME_W-1:0] BLANK_NAME = '0
) (
   input  logic              vga_clk,
   input  logic              rst_n,
   input  logic              active,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_confirm,
   output logic              name_req,
   output logic [2:0]        name_addr,
   input  logic              name_ack,
   input  logic [NAME_W-1:0] name_data,
   output logic              repertoire_page,
   output logic [1:0]        page_song_id,
   output logic [NAME_W-1:0] songname_1,
   output logic [NAME_W-1:0] songname_2,
   output logic [NAME_W-1:0] songname_3,
   output logic [NAME_W-1:0] songname_4,
   output logic              busy,
   output logic              sel_valid,
   output logic [2:0]        sel_id
);

   // state   | meaning
   // START   | clear slot counter, begin page load
   // FETCH   | request name for slot, or blank it if past SONG_COUNT
   // NEXT    | one-cycle request gap, advance slot
   // COMMIT  | publish staged names and pending cursor together
   // READY   | idle, accepting button pulses
   typedef enum logic [2:0] {
      ST_START,
      ST_FETCH,
      ST_NEXT,
      ST_COMMIT,
      ST_READY
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(SONG_COUNT - 1);
   localparam logic [3:0] COUNT4   = 4'(SONG_COUNT);

   state_t            state_q;
   logic [1:0]        slot_q;
   logic              pend_page_q;
   logic [1:0]        pend_slot_q;
   logic              page_q;
   logic [1:0]        hl_q;
   logic [NAME_W-1:0] stage_q [4];
   logic [NAME_W-1:0] name_q  [4];
   logic              req_q;
   logic [2:0]        addr_q;
   logic              sel_valid_q;
   logic [2:0]        sel_id_q;

   logic [2:0] cur;
   logic [2:0] cur_d;
   logic [2:0] fetch_idx;
   logic       fetch_blank;
   logic       move_up;
   logic       move_dn;

   assign cur         = {page_q, hl_q};
   assign fetch_idx   = {pend_page_q, slot_q};
   assign fetch_blank = ({1'b0, fetch_idx} >= COUNT4);
   assign move_up     = btn_up & ~btn_down;
   assign move_dn     = btn_down & ~btn_up;

   always_comb begin
      cur_d = cur;
      if (move_dn) begin
         if (cur == LAST_IDX) begin
`ifdef SONG_WRAP_EN
            cur_d = 3'd0;
`else
            cur_d = cur;
`endif
         end else begin
            cur_d = cur + 3'd1;
         end
      end else if (move_up) begin
         if (cur == 3'd0) begin
`ifdef SONG_WRAP_EN
            cur_d = LAST_IDX;
`else
            cur_d = cur;
`endif
         end else begin
            cur_d = cur - 3'd1;
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (!rst_n) begin
         state_q     <= ST_START;
         slot_q      <= 2'd0;
         pend_page_q <= 1'b0;
         pend_slot_q <= 2'd0;
         page_q      <= 1'b0;
         hl_q        <= 2'd0;
         req_q       <= 1'b0;
         addr_q      <= 3'd0;
         sel_valid_q <= 1'b0;
         sel_id_q    <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            stage_q[i] <= BLANK_NAME;
            name_q[i]  <= BLANK_NAME;
         end
      end else begin
         sel_valid_q <= 1'b0;
         case (state_q)
            ST_START: begin
               slot_q  <= 2'd0;
               state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               if (fetch_blank) begin
                  stage_q[slot_q] <= BLANK_NAME;
                  state_q         <= ST_NEXT;
               end else if (!req_q) begin
                  req_q  <= 1'b1;
                  addr_q <= fetch_idx;
               end else if (name_ack) begin
                  stage_q[slot_q] <= name_data;
                  req_q           <= 1'b0;
                  state_q         <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (slot_q == 2'd3) begin
                  state_q <= ST_COMMIT;
               end else begin
                  slot_q  <= slot_q + 2'd1;
                  state_q <= ST_FETCH;
               end
            end
            ST_COMMIT: begin
               name_q  <= stage_q;
               page_q  <= pend_page_q;
               hl_q    <= pend_slot_q;
               state_q <= ST_READY;
            end
            ST_READY: begin
               if (active) begin
                  if (btn_confirm) begin
                     sel_valid_q <= 1'b1;
                     sel_id_q    <= cur;
                  end else if (cur_d[2] != page_q) begin
                     // displayed page and highlight stay put until the new page commits
                     pend_page_q <= cur_d[2];
                     pend_slot_q <= cur_d[1:0];
                     slot_q      <= 2'd0;
                     state_q     <= ST_FETCH;
                  end else begin
                     hl_q        <= cur_d[1:0];
                     pend_slot_q <= cur_d[1:0];
                  end
               end
            end
            default: state_q <= ST_START;
         endcase
      end
   end

   assign name_req        = req_q;
   assign name_addr       = addr_q;
   assign repertoire_page = page_q;
   assign page_song_id    = hl_q;
   assign songname_1      = name_q[0];
   assign songname_2      = name_q[1];
   assign songname_3      = name_q[2];
   assign songname_4      = name_q[3];
   assign busy            = (state_q != ST_READY);
   assign sel_valid       = sel_valid_q;
   assign sel_id          = sel_id_q;

endmodule
